// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the delay-line sequencer: FSM encodings and a
// constant clog2 used to size the delay/occupancy fields.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_RUN   = 2'd1,
        DC_DRAIN = 2'd2
    } dc_state_e;

    function automatic int dc_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/delay_vld_pipe.sv
// Valid-token shift register for the delay line. Bits at or beyond the
// active length are held at zero so the last active bit is the output tap.
module delay_vld_pipe #(
    parameter int NMAX = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            step,
    input  logic            tok_in,
    input  logic [NMAX-1:0] len_mask,
    output logic            tap
);

    logic [NMAX-1:0] vld_q;
    logic [NMAX-1:0] vld_d;
    logic [NMAX-1:0] shifted;

    generate
        if (NMAX == 1) begin : g_single
            assign shifted = tok_in;
        end else begin : g_multi
            assign shifted = {vld_q[NMAX-2:0], tok_in};
        end
    endgenerate

    always_comb begin
        vld_d = vld_q;
        if (step) vld_d = shifted & len_mask;
    end

    always_ff @(posedge clk) begin
        if (clr) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // The highest set mask bit marks tap D-1; pick that bit out of the line.
    assign tap = |(vld_q & len_mask & ~(len_mask >> 1));

endmodule

// File: rtl/delay_ctrl.sv
// Sequencer for a step-gated delay line: handshake, stall, drain and tap select.
// Optional stall-cycle statistics are built when DELAY_CTRL_STATS_EN is defined.
module delay_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int NMAX = 16,
    parameter int CW   = dc_clog2(NMAX + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_delay,
    output logic          cfg_err,
    input  logic          drain_req,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          step,
    output logic [CW-1:0] tap_sel,
    output logic [CW-1:0] occupancy,
    output logic          busy,
    output logic [31:0]   stall_cnt
);

    dc_state_e       state_q;
    logic [CW-1:0]   dly_q;
    logic [CW-1:0]   dly_d;
    logic [CW-1:0]   occ_q;
    logic [CW-1:0]   occ_d;
    logic            cfg_err_q;
    logic            cfg_err_d;
    logic            stall;
    logic            accept;
    logic            deq;
    logic            cfg_ok;
    logic [NMAX-1:0] len_mask;

    function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] v);
        if (v == '0)         return CW'(1);
        if (v > CW'(NMAX))   return CW'(NMAX);
        return v;
    endfunction

    // The whole line freezes while the consumer refuses the output token.
    assign stall    = out_valid & ~out_ready;
    assign step     = ~stall;
    assign in_ready = ~stall & (state_q != DC_DRAIN);
    assign accept   = in_valid & in_ready;
    assign deq      = out_valid & out_ready;

    always_comb begin
        for (int i = 0; i < NMAX; i++) len_mask[i] = (CW'(i) < dly_q);
    end

    delay_vld_pipe #(.NMAX(NMAX)) u_vld_pipe (
        .clk      (clk),
        .clr      (clr),
        .step     (step),
        .tok_in   (accept),
        .len_mask (len_mask),
        .tap      (out_valid)
    );

    // Delay only changes with an empty line, so the mask never cuts a live token.
    assign cfg_ok    = cfg_we & (state_q == DC_IDLE) & ~accept;
    assign cfg_err_d = cfg_we & ~cfg_ok;

    always_comb begin
        dly_d = dly_q;
        if (cfg_ok) dly_d = clamp_delay(cfg_delay);
    end

    always_comb begin
        occ_d = occ_q;
        case ({accept, deq})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= DC_IDLE;
            dly_q     <= CW'(1);
            occ_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            dly_q     <= dly_d;
            occ_q     <= occ_d;
            cfg_err_q <= cfg_err_d;
            case (state_q)
                DC_IDLE: begin
                    if (accept) state_q <= DC_RUN;
                end
                DC_RUN: begin
                    if (drain_req)          state_q <= DC_DRAIN;
                    else if (occ_d == '0)   state_q <= DC_IDLE;
                end
                DC_DRAIN: begin
                    if (occ_d == '0) state_q <= DC_IDLE;
                end
                default: state_q <= DC_IDLE;
            endcase
        end
    end

    assign tap_sel   = dly_q - CW'(1);
    assign occupancy = occ_q;
    assign busy      = (state_q != DC_IDLE);
    assign cfg_err   = cfg_err_q;

`ifdef DELAY_CTRL_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (clr)                            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
